// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helpers, reused by sibling FIFO designs.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  // Pointer width: wraps naturally from DEPTH-1 to 0 for power-of-two depths.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so DEPTH itself is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Request/response bundle of fifo_param; the slave side is the FIFO itself.
interface fifo_param_if #(
  parameter int unsigned WIDTH = fifo_pkg::DEF_WIDTH,
  parameter int unsigned DEPTH = fifo_pkg::DEF_DEPTH
);
  localparam int unsigned CW = fifo_pkg::cnt_w(DEPTH);

  logic             clr;
  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             error;
  logic             ovf_sticky;
  logic             udf_sticky;

  modport master (
    output clr, wen, ren, din,
    input  dout, rvalid, full, empty, almost_full, almost_empty,
           count, error, ovf_sticky, udf_sticky
  );

  modport slave (
    input  clr, wen, ren, din,
    output dout, rvalid, full, empty, almost_full, almost_empty,
           count, error, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// DEPTH x WIDTH storage: one synchronous write port, one synchronous read port, no reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read-before-write on a shared address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: pointers, occupancy, flags and sticky error tracking.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0]    waddr_q, waddr_d;
  logic [PW-1:0]    raddr_q, raddr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             loaded_q, loaded_d;

  logic             full_c, empty_c;
  logic             wr_ok_c, rd_ok_c;
  logic             mem_we_c, mem_re_c;
  logic [WIDTH-1:0] rdata;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign wr_ok_c = bus.wen && (!full_c || bus.ren);
  assign rd_ok_c = bus.ren && !empty_c;

  // Next-state: clr wins over both requests; otherwise each accepted half proceeds.
  always_comb begin
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    count_d  = count_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    loaded_d = loaded_q;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;
    if (bus.clr) begin
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      mem_we_c = wr_ok_c;
      mem_re_c = rd_ok_c;
      rvalid_d = rd_ok_c;
      if (rd_ok_c) loaded_d = 1'b1;
      if (wr_ok_c) waddr_d = waddr_q + PW'(1);
      if (rd_ok_c) raddr_d = raddr_q + PW'(1);
      if (wr_ok_c && !rd_ok_c) count_d = count_q + CW'(1);
      if (rd_ok_c && !wr_ok_c) count_d = count_q - CW'(1);
      if (bus.wen && full_c && !bus.ren) ovf_d = 1'b1;
      if (bus.ren && empty_c) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      loaded_q <= loaded_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (waddr_q),
    .wdata (bus.din),
    .re    (mem_re_c),
    .raddr (raddr_q),
    .rdata (rdata)
  );

  // Storage has no reset, so dout reads as zero until the first accepted read.
  assign bus.dout         = loaded_q ? rdata : '0;
  assign bus.rvalid       = rvalid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.error        = (bus.ren && empty_c) || (bus.wen && full_c && !bus.ren);
  assign bus.ovf_sticky   = ovf_q;
  assign bus.udf_sticky   = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param against a queue-based reference model.
module tb_fifo_param;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic clk;
  logic rst;

  fifo_param_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

  fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of stored words plus the observable registers.
  logic [7:0] mq[$];
  logic [7:0] m_dout   = 8'h00;
  logic       m_rvalid = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       m_udf    = 1'b0;
  logic       err_obs, err_exp;

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One clock cycle of stimulus; error is sampled before the edge, state after it.
  task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
    int sz;
    bus.wen = w; bus.ren = r; bus.din = d; bus.clr = c;
    #1;
    err_obs = bus.error;
    sz = mq.size();
    err_exp = (r && sz == 0) || (w && sz == DEPTH && !r);
    @(posedge clk);
    if (c) begin
      mq.delete(); m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_rvalid = r && (sz != 0);
      if (m_rvalid) m_dout = mq.pop_front();
      if (w && (sz != DEPTH || r)) mq.push_back(d);
      if (w && sz == DEPTH && !r) m_ovf = 1'b1;
      if (r && sz == 0) m_udf = 1'b1;
    end
    #1;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got empty=%b full=%b exp 1/0", bus.empty, bus.full); end
    n_checks++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_almost: got ae=%b af=%b exp 1/0", bus.almost_empty, bus.almost_full); end
    n_checks++; if (bus.dout !== 8'h00 || bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dout: got %h/%b exp 00/0", bus.dout, bus.rvalid); end
    n_checks++; if (bus.ovf_sticky !== 1'b0 || bus.udf_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b%b exp 00", bus.ovf_sticky, bus.udf_sticky); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
    n_checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d exp 1/8", bus.full, bus.count); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (bus.rvalid !== 1'b1 || bus.dout !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_%0d: got %h/%b exp %h/1", i, bus.dout, bus.rvalid, 8'(i + 1)); end
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b exp 1", bus.empty); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++; if (bus.rvalid !== 1'b0 || bus.dout !== 8'h08) begin n_fail++; $display("FAIL idle_hold: got %h/%b exp 08/0", bus.dout, bus.rvalid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 254)), 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    n_checks++; if (err_obs !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b exp 1", err_obs); end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d exp 8", bus.count); end
    n_checks++; if (bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", bus.ovf_sticky); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (bus.dout === 8'hFF || bus.dout !== m_dout) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h exp %h", i, bus.dout, m_dout); end
    end
  endtask

  task automatic test_empty_simul();
    logic [7:0] prev;
    prev = bus.dout;
    drive(1'b1, 1'b1, 8'hA5, 1'b0);
    n_checks++; if (err_obs !== 1'b1) begin n_fail++; $display("FAIL es_error: got %b exp 1", err_obs); end
    n_checks++; if (bus.rvalid !== 1'b0 || bus.dout !== prev) begin n_fail++; $display("FAIL es_rvalid: got %h/%b exp %h/0", bus.dout, bus.rvalid, prev); end
    n_checks++; if (bus.count !== 4'd1 || bus.udf_sticky !== 1'b1) begin n_fail++; $display("FAIL es_count: got %0d/%b exp 1/1", bus.count, bus.udf_sticky); end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (bus.dout !== 8'hA5 || bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL es_read: got %h/%b exp a5/1", bus.dout, bus.rvalid); end
  endtask

  task automatic test_full_wrap();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (bus.ovf_sticky !== 1'b0 || bus.udf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b%b exp 00", bus.ovf_sticky, bus.udf_sticky); end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    n_checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %0d/%b exp 8/1", bus.count, bus.full); end
    drive(1'b1, 1'b1, 8'h3C, 1'b0);
    n_checks++; if (err_obs !== 1'b0) begin n_fail++; $display("FAIL fs_error: got %b exp 0", err_obs); end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fs_count: got %0d exp 8", bus.count); end
    n_checks++; if (bus.dout !== 8'h14 || bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL fs_oldest: got %h/%b exp 14/1", bus.dout, bus.rvalid); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (bus.dout !== m_dout) begin n_fail++; $display("FAIL fs_drain_%0d: got %h exp %h", i, bus.dout, m_dout); end
    end
    n_checks++; if (bus.dout !== 8'h3C) begin n_fail++; $display("FAIL fs_last: got %h exp 3c", bus.dout); end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 16; i++) begin
      drive(i < 8, i >= 8, 8'(i), 1'b0);
      n_checks++;
      if (bus.almost_full !== (mq.size() >= AF) || bus.almost_empty !== (mq.size() <= AE)) begin
        n_fail++; $display("FAIL thr_%0d: got af=%b ae=%b exp af=%b ae=%b at count %0d", i, bus.almost_full, bus.almost_empty, mq.size() >= AF, mq.size() <= AE, mq.size());
      end
    end
  endtask

  task automatic test_clr();
    logic [7:0] prev;
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    n_checks++; if (bus.count !== 4'd3 || bus.udf_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got %0d/%b exp 3/1", bus.count, bus.udf_sticky); end
    prev = bus.dout;
    drive(1'b1, 1'b0, 8'h77, 1'b1);
    n_checks++; if (bus.count !== 4'd0 || bus.udf_sticky !== 1'b0 || bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_state: got %0d/%b%b exp 0/00", bus.count, bus.ovf_sticky, bus.udf_sticky); end
    n_checks++; if (bus.rvalid !== 1'b0 || bus.dout !== prev) begin n_fail++; $display("FAIL clr_dout: got %h/%b exp %h/0", bus.dout, bus.rvalid, prev); end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (bus.rvalid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_discard: got rvalid=%b empty=%b exp 0/1", bus.rvalid, bus.empty); end
  endtask

  task automatic test_async_rst();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h45, 1'b0);
    bus.wen = 1'b1; bus.din = 8'h46;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL arst_count: got %0d/%b exp 0/1", bus.count, bus.empty); end
    n_checks++; if (bus.dout !== 8'h00 || bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL arst_dout: got %h/%b exp 00/0", bus.dout, bus.ovf_sticky); end
    @(posedge clk); #1;
    rst = 1'b0; bus.wen = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (bus.dout !== 8'h5A || bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL arst_resume: got %h/%b exp 5a/1", bus.dout, bus.rvalid); end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 2);
      drive(w, r, 8'($urandom), c);
      n_checks++;
      if (err_obs !== err_exp || bus.count !== 4'(mq.size()) || bus.rvalid !== m_rvalid || bus.dout !== m_dout
          || bus.ovf_sticky !== m_ovf || bus.udf_sticky !== m_udf
          || bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)
          || bus.almost_full !== (mq.size() >= AF) || bus.almost_empty !== (mq.size() <= AE)) begin
        n_fail++;
        $display("FAIL rnd_%0d: got err=%b cnt=%0d rv=%b dout=%h ovf=%b udf=%b exp err=%b cnt=%0d rv=%b dout=%h ovf=%b udf=%b",
                 i, err_obs, bus.count, bus.rvalid, bus.dout, bus.ovf_sticky, bus.udf_sticky,
                 err_exp, mq.size(), m_rvalid, m_dout, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clr = 1'b0; bus.din = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_fill_drain();
    test_overflow();
    test_empty_simul();
    test_full_wrap();
    test_thresholds();
    test_clr();
    test_async_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
